// File: rtl/core_pkg.sv
// Shared encodings, FSM states and packet layout for the core's pipeline stages.
// The packet struct is sized by the XLEN/REG_W defaults below.
package core_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int REG_W_DEF = 5;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC  = 2'b10;

  typedef enum logic {
    IDLE,
    MEM_WAIT
  } state_t;

  typedef enum logic [1:0] {
    KIND_ALU,
    KIND_LOAD,
    KIND_STORE
  } kind_t;

  typedef struct packed {
    logic [REG_W_DEF-1:0] rd;
    logic                 reg_write;
    kind_t                kind;
    logic [XLEN_DEF-1:0]  data;
  } ex_mem_pkt_t;

  // mem_write wins over any mem_to_reg encoding; 2'b11 falls back to ALU.
  function automatic kind_t classify(input logic mem_write, input logic [1:0] mem_to_reg);
    if (mem_write)
      return KIND_STORE;
    else if (mem_to_reg == WB_MEM)
      return KIND_LOAD;
    else
      return KIND_ALU;
  endfunction

endpackage

// File: rtl/ex_mem_stage.sv
// EX/MEM register and data-memory sequencer: ALU ops retire 1 cycle after accept, memory ops 1 cycle
// after mem_ready. Upstream is stalled for the whole time a memory request is outstanding.
module ex_mem_stage
  import core_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int REG_W = REG_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_valid,
  input  logic             flush,
  input  logic [XLEN-1:0]  alu_result,
  input  logic [XLEN-1:0]  store_data,
  input  logic [XLEN-1:0]  pc_count,
  input  logic [REG_W-1:0] rd,
  input  logic             reg_write,
  input  logic             mem_write,
  input  logic [1:0]       mem_to_reg,
  output logic             stall_out,
  output logic             mem_req,
  output logic             mem_we,
  output logic [XLEN-1:0]  mem_addr,
  output logic [XLEN-1:0]  mem_wdata,
  input  logic             mem_ready,
  input  logic [XLEN-1:0]  mem_rdata,
  output logic             wb_valid,
  output logic             wb_reg_write,
  output logic [REG_W-1:0] wb_rd,
  output logic [XLEN-1:0]  wb_data
);

  state_t      state;
  ex_mem_pkt_t pend_pkt;
  ex_mem_pkt_t wb_pkt;
  ex_mem_pkt_t pkt_in;
  kind_t       kind_in;
  logic        accept;
  logic        mem_we_q;
  logic [XLEN-1:0] mem_addr_q;
  logic [XLEN-1:0] mem_wdata_q;

  assign kind_in = classify(mem_write, mem_to_reg);
  assign accept  = ex_valid & ~stall_out & ~flush;

  // x0 and store suppression is folded in at accept so the wb side just copies the packet.
  always_comb begin
    pkt_in           = '0;
    pkt_in.rd        = rd;
    pkt_in.kind      = kind_in;
    pkt_in.reg_write = reg_write & (rd != '0) & (kind_in != KIND_STORE);
    if (kind_in == KIND_ALU)
      pkt_in.data = (mem_to_reg == WB_PC) ? pc_count : alu_result;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pend_pkt    <= '0;
      wb_pkt      <= '0;
      wb_valid    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      wb_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            if (kind_in == KIND_ALU) begin
              wb_pkt   <= pkt_in;
              wb_valid <= 1'b1;
            end else begin
              pend_pkt    <= pkt_in;
              mem_addr_q  <= alu_result;
              mem_wdata_q <= store_data;
              mem_we_q    <= (kind_in == KIND_STORE);
              state       <= MEM_WAIT;
            end
          end
        end
        MEM_WAIT: begin
          if (mem_ready) begin
            wb_pkt <= pend_pkt;
            if (pend_pkt.kind == KIND_LOAD)
              wb_pkt.data <= mem_rdata;
            wb_valid <= 1'b1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    stall_out    = (state == MEM_WAIT);
    mem_req      = (state == MEM_WAIT);
    mem_we       = mem_we_q & (state == MEM_WAIT);
    mem_addr     = mem_addr_q;
    mem_wdata    = mem_wdata_q;
    wb_reg_write = wb_pkt.reg_write;
    wb_rd        = wb_pkt.rd;
    wb_data      = wb_pkt.data;
  end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed plus randomized checks of ex_mem_stage against a transaction-level reference model.
module tb_ex_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, flush;
  logic [31:0] alu_result, store_data, pc_count;
  logic [4:0]  rd;
  logic        reg_write, mem_write;
  logic [1:0]  mem_to_reg;
  logic        stall_out, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        wb_valid, wb_reg_write;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  int n_checks = 0;
  int n_fail   = 0;

  logic [4:0]  last_rd;
  logic [31:0] last_data;
  logic        last_rw;

  ex_mem_stage dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .flush(flush),
    .alu_result(alu_result), .store_data(store_data), .pc_count(pc_count),
    .rd(rd), .reg_write(reg_write), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
    .stall_out(stall_out), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Write-back value straight from the instruction-type rules.
  function automatic logic [31:0] ref_data(input logic mw, input logic [1:0] mtr,
                                           input logic [31:0] alu, input logic [31:0] pc,
                                           input logic [31:0] rdata);
    if (mw) return 32'h0;
    case (mtr)
      2'b01:   return rdata;
      2'b10:   return pc;
      default: return alu;
    endcase
  endfunction

  task automatic scramble_inputs();
    alu_result = $urandom;
    store_data = $urandom;
    pc_count   = $urandom;
    rd         = 5'($urandom_range(0, 31));
    reg_write  = 1'($urandom_range(0, 1));
    mem_write  = 1'($urandom_range(0, 1));
    mem_to_reg = 2'($urandom_range(0, 3));
  endtask

  task automatic check_wb(input string tag, input logic [4:0] exp_rd,
                          input logic exp_rw, input logic [31:0] exp_data);
    chk({tag, ".wb_valid"}, 32'(wb_valid), 32'd1);
    chk({tag, ".wb_rd"}, 32'(wb_rd), 32'(exp_rd));
    chk({tag, ".wb_reg_write"}, 32'(wb_reg_write), 32'(exp_rw));
    chk({tag, ".wb_data"}, wb_data, exp_data);
    last_rd   = exp_rd;
    last_rw   = exp_rw;
    last_data = exp_data;
  endtask

  // A cycle in which nothing may be accepted; stray mem_ready must be ignored.
  task automatic idle_cycle(input string tag);
    ex_valid  = 1'($urandom_range(0, 1));
    flush     = ex_valid;
    mem_ready = 1'b1;
    mem_rdata = $urandom;
    scramble_inputs();
    @(negedge clk);
    chk({tag, ".idle.wb_valid"}, 32'(wb_valid), 32'd0);
    chk({tag, ".idle.mem_req"}, 32'(mem_req), 32'd0);
    chk({tag, ".idle.stall"}, 32'(stall_out), 32'd0);
    chk({tag, ".idle.wb_rd_hold"}, 32'(wb_rd), 32'(last_rd));
    chk({tag, ".idle.wb_data_hold"}, wb_data, last_data);
    chk({tag, ".idle.wb_rw_hold"}, 32'(wb_reg_write), 32'(last_rw));
    ex_valid  = 1'b0;
    flush     = 1'b0;
    mem_ready = 1'b0;
  endtask

  // Presents one instruction, then follows it to retirement. Called on a negedge.
  task automatic issue(input string tag, input logic mw, input logic [1:0] mtr,
                       input logic rw, input logic [4:0] dst, input logic [31:0] alu,
                       input logic [31:0] sd, input logic [31:0] pc, input logic fl,
                       input int wait_n, input logic [31:0] rdata);
    logic is_mem;
    is_mem     = mw || (mtr == 2'b01);
    ex_valid   = 1'b1;
    flush      = fl;
    mem_write  = mw;
    mem_to_reg = mtr;
    reg_write  = rw;
    rd         = dst;
    alu_result = alu;
    store_data = sd;
    pc_count   = pc;
    mem_ready  = 1'b0;
    @(negedge clk);
    ex_valid = 1'b0;
    flush    = 1'b0;
    scramble_inputs();
    if (fl) begin
      chk({tag, ".flush.wb_valid"}, 32'(wb_valid), 32'd0);
      chk({tag, ".flush.mem_req"}, 32'(mem_req), 32'd0);
      chk({tag, ".flush.wb_data_hold"}, wb_data, last_data);
    end else if (!is_mem) begin
      chk({tag, ".alu.mem_req"}, 32'(mem_req), 32'd0);
      chk({tag, ".alu.stall"}, 32'(stall_out), 32'd0);
      check_wb(tag, dst, rw && (dst != 5'd0), ref_data(mw, mtr, alu, pc, rdata));
    end else begin
      for (int i = 0; i <= wait_n; i++) begin
        chk({tag, ".mem.req"}, 32'(mem_req), 32'd1);
        chk({tag, ".mem.stall"}, 32'(stall_out), 32'd1);
        chk({tag, ".mem.addr"}, mem_addr, alu);
        chk({tag, ".mem.we"}, 32'(mem_we), 32'(mw));
        chk({tag, ".mem.wdata"}, mem_wdata, sd);
        chk({tag, ".mem.wb_valid"}, 32'(wb_valid), 32'd0);
        mem_ready = (i == wait_n);
        mem_rdata = (i == wait_n) ? rdata : $urandom;
        // A committed memory op ignores new work and flushes alike.
        ex_valid  = 1'b1;
        flush     = 1'(i % 2);
        @(negedge clk);
      end
      mem_ready = 1'b0;
      ex_valid  = 1'b0;
      flush     = 1'b0;
      chk({tag, ".done.mem_req"}, 32'(mem_req), 32'd0);
      chk({tag, ".done.stall"}, 32'(stall_out), 32'd0);
      check_wb(tag, dst, rw && (dst != 5'd0) && !mw, ref_data(mw, mtr, alu, pc, rdata));
    end
  endtask

  initial begin
    logic        r_mw, r_rw, r_fl;
    logic [1:0]  r_mtr;
    logic [4:0]  r_rd;
    int          r_wait;

    rst = 1'b1; ex_valid = 1'b0; flush = 1'b0; mem_ready = 1'b0; mem_rdata = '0;
    alu_result = '0; store_data = '0; pc_count = '0; rd = '0;
    reg_write = 1'b0; mem_write = 1'b0; mem_to_reg = 2'b00;
    last_rd = '0; last_rw = 1'b0; last_data = '0;
    repeat (2) @(negedge clk);
    chk("reset.wb_valid", 32'(wb_valid), 32'd0);
    chk("reset.mem_req", 32'(mem_req), 32'd0);
    chk("reset.mem_we", 32'(mem_we), 32'd0);
    chk("reset.stall", 32'(stall_out), 32'd0);
    chk("reset.wb_reg_write", 32'(wb_reg_write), 32'd0);
    chk("reset.mem_addr", mem_addr, 32'd0);
    chk("reset.mem_wdata", mem_wdata, 32'd0);
    chk("reset.wb_data", wb_data, 32'd0);
    chk("reset.wb_rd", 32'(wb_rd), 32'd0);
    rst = 1'b0;

    issue("alu", 1'b0, 2'b00, 1'b1, 5'd5, 32'h0000_1234, 32'h0, 32'h0, 1'b0, 0, 32'h0);
    idle_cycle("alu");
    issue("load3", 1'b0, 2'b01, 1'b1, 5'd7, 32'h0000_0100, 32'h1111_2222, 32'h0, 1'b0, 2, 32'hDEAD_BEEF);
    issue("store0", 1'b1, 2'b01, 1'b1, 5'd3, 32'h0000_0200, 32'h0000_CAFE, 32'h0, 1'b0, 0, 32'h0);
    issue("x0", 1'b0, 2'b00, 1'b1, 5'd0, 32'h5555_AAAA, 32'h0, 32'h0, 1'b0, 0, 32'h0);
    issue("link", 1'b0, 2'b10, 1'b1, 5'd9, 32'h7777_0000, 32'h0, 32'h0000_0040, 1'b0, 0, 32'h0);
    issue("rsvd", 1'b0, 2'b11, 1'b1, 5'd10, 32'h0BAD_F00D, 32'h0, 32'h0000_0044, 1'b0, 0, 32'h0);
    issue("flush", 1'b0, 2'b00, 1'b1, 5'd6, 32'h0000_9999, 32'h0, 32'h0, 1'b1, 0, 32'h0);
    issue("load_fl", 1'b0, 2'b01, 1'b1, 5'd8, 32'h0000_0180, 32'h0, 32'h0, 1'b0, 3, 32'h1234_5678);
    idle_cycle("post_load");

    // Reset while a load is outstanding: request dropped, nothing retires.
    ex_valid = 1'b1; mem_write = 1'b0; mem_to_reg = 2'b01; reg_write = 1'b1;
    rd = 5'd4; alu_result = 32'h0000_0300;
    @(negedge clk);
    ex_valid = 1'b0;
    chk("rstmid.mem_req_before", 32'(mem_req), 32'd1);
    @(negedge clk);
    rst = 1'b1; mem_ready = 1'b1; mem_rdata = 32'hFFFF_0000;
    @(negedge clk);
    rst = 1'b0; mem_ready = 1'b0;
    chk("rstmid.mem_req", 32'(mem_req), 32'd0);
    chk("rstmid.stall", 32'(stall_out), 32'd0);
    chk("rstmid.wb_valid", 32'(wb_valid), 32'd0);
    last_rd = '0; last_rw = 1'b0; last_data = '0;
    idle_cycle("rstmid");
    issue("rstmid.load", 1'b0, 2'b01, 1'b1, 5'd12, 32'h0000_0400, 32'h0, 32'h0, 1'b0, 1, 32'hA5A5_5A5A);

    for (int n = 0; n < 60; n++) begin
      r_mw   = ($urandom_range(0, 3) == 0);
      r_mtr  = 2'($urandom_range(0, 3));
      r_rw   = 1'($urandom_range(0, 1));
      r_rd   = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      r_fl   = ($urandom_range(0, 7) == 0);
      r_wait = $urandom_range(0, 3);
      issue("rand", r_mw, r_mtr, r_rw, r_rd, $urandom, $urandom, $urandom, r_fl, r_wait, $urandom);
      if ($urandom_range(0, 4) == 0) idle_cycle("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
